// File: rtl/argon_wb_arbiter_if.sv
// Writeback request, register-file write and scoreboard signals for argon_wb_arbiter.
// ARGON_WB_FORWARD_EN adds the same-cycle forwarding outputs.
interface argon_wb_arbiter_if #(
  parameter int REQUESTERS = 2,
  parameter int INDEXWIDTH = 3,
  parameter int DATAWIDTH  = 16
);
  logic [REQUESTERS-1:0]            i_req_valid;
  logic [REQUESTERS*INDEXWIDTH-1:0] i_req_index;
  logic [REQUESTERS*DATAWIDTH-1:0]  i_req_data;
  logic [REQUESTERS-1:0]            o_req_ready;
  logic                             o_writeEn;
  logic [INDEXWIDTH-1:0]            o_selectW;
  logic [DATAWIDTH-1:0]             o_wdata;
  logic                             i_rsv_en;
  logic [INDEXWIDTH-1:0]            i_rsv_index;
  logic                             o_rsv_stall;
  logic [INDEXWIDTH-1:0]            i_chkA;
  logic [INDEXWIDTH-1:0]            i_chkB;
  logic                             o_busyA;
  logic                             o_busyB;
`ifdef ARGON_WB_FORWARD_EN
  logic                             o_fwdA_valid;
  logic                             o_fwdB_valid;
  logic [DATAWIDTH-1:0]             o_fwdA_data;
  logic [DATAWIDTH-1:0]             o_fwdB_data;

  modport master (
    output i_req_valid, i_req_index, i_req_data, i_rsv_en, i_rsv_index, i_chkA, i_chkB,
    input  o_req_ready, o_writeEn, o_selectW, o_wdata, o_rsv_stall, o_busyA, o_busyB,
    input  o_fwdA_valid, o_fwdB_valid, o_fwdA_data, o_fwdB_data
  );
  modport slave (
    input  i_req_valid, i_req_index, i_req_data, i_rsv_en, i_rsv_index, i_chkA, i_chkB,
    output o_req_ready, o_writeEn, o_selectW, o_wdata, o_rsv_stall, o_busyA, o_busyB,
    output o_fwdA_valid, o_fwdB_valid, o_fwdA_data, o_fwdB_data
  );
`else
  modport master (
    output i_req_valid, i_req_index, i_req_data, i_rsv_en, i_rsv_index, i_chkA, i_chkB,
    input  o_req_ready, o_writeEn, o_selectW, o_wdata, o_rsv_stall, o_busyA, o_busyB
  );
  modport slave (
    input  i_req_valid, i_req_index, i_req_data, i_rsv_en, i_rsv_index, i_chkA, i_chkB,
    output o_req_ready, o_writeEn, o_selectW, o_wdata, o_rsv_stall, o_busyA, o_busyB
  );
`endif
endinterface

// File: rtl/argon_wb_arbiter.sv
// Round-robin writeback arbiter for the register-file write port plus a busy-bit scoreboard.
// Optional ARGON_WB_FORWARD_EN exposes the registered write as same-cycle forwarding data.
module argon_wb_arbiter #(
  parameter int REQUESTERS = 2,
  parameter int REGISTERS  = 8,
  parameter int INDEXWIDTH = 3,
  parameter int DATAWIDTH  = 16
) (
  input logic              i_clk,
  input logic              i_reset_n,
  argon_wb_arbiter_if.slave bus
);
  localparam int PTRW = (REQUESTERS > 2) ? 2 : 1;

  logic [PTRW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [REQUESTERS-1:0]  grant;
  logic                   grant_any;
  logic [INDEXWIDTH-1:0]  sel_index;
  logic [DATAWIDTH-1:0]   sel_data;
  logic                   wr_en;
  logic                   wen_q;
  logic [INDEXWIDTH-1:0]  selw_q;
  logic [DATAWIDTH-1:0]   wdata_q;
  logic [REGISTERS-1:1]   busy_q, busy_d;
  logic                   rsv_busy, rsv_req, rsv_same, rsv_stall, set_en;
  logic                   busy_a, busy_b;
  int                     k;

  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    sel_index = '0;
    sel_data  = '0;
    rr_ptr_d  = rr_ptr_q;
    k         = 0;
    for (int i = 0; i < REQUESTERS; i++) begin
      k = (int'(rr_ptr_q) + i) % REQUESTERS;
      if (!grant_any && bus.i_req_valid[k]) begin
        grant_any = 1'b1;
        grant[k]  = 1'b1;
        sel_index = bus.i_req_index[k*INDEXWIDTH +: INDEXWIDTH];
        sel_data  = bus.i_req_data[k*DATAWIDTH +: DATAWIDTH];
        rr_ptr_d  = PTRW'((k + 1) % REQUESTERS);
      end
    end
  end

  // Index 0 completes the handshake but never reaches the regfile or scoreboard.
  assign wr_en = grant_any && (sel_index != '0);

  always_comb begin
    rsv_busy = 1'b0;
    busy_a   = 1'b0;
    busy_b   = 1'b0;
    for (int r = 1; r < REGISTERS; r++) begin
      if (bus.i_rsv_index == INDEXWIDTH'(r)) rsv_busy = busy_q[r];
      if (bus.i_chkA == INDEXWIDTH'(r))      busy_a   = busy_q[r];
      if (bus.i_chkB == INDEXWIDTH'(r))      busy_b   = busy_q[r];
    end
  end

  assign rsv_req   = bus.i_rsv_en && (bus.i_rsv_index != '0);
  assign rsv_same  = wr_en && (sel_index == bus.i_rsv_index);
  assign rsv_stall = rsv_req && rsv_busy && !rsv_same;
  assign set_en    = rsv_req && !rsv_stall;

  // Clear applies before set so a same-edge retire and re-reserve leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < REGISTERS; r++) begin
      if (wr_en && sel_index == INDEXWIDTH'(r))            busy_d[r] = 1'b0;
      if (set_en && bus.i_rsv_index == INDEXWIDTH'(r))     busy_d[r] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rr_ptr_q <= '0;
      busy_q   <= '0;
      wen_q    <= 1'b0;
      selw_q   <= '0;
      wdata_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      busy_q   <= busy_d;
      wen_q    <= wr_en;
      if (wr_en) begin
        selw_q  <= sel_index;
        wdata_q <= sel_data;
      end
    end
  end

  assign bus.o_req_ready = grant;
  assign bus.o_writeEn   = wen_q;
  assign bus.o_selectW   = selw_q;
  assign bus.o_wdata     = wdata_q;
  assign bus.o_rsv_stall = rsv_stall;
  assign bus.o_busyA     = busy_a;
  assign bus.o_busyB     = busy_b;

`ifdef ARGON_WB_FORWARD_EN
  assign bus.o_fwdA_valid = wen_q && (selw_q != '0) && (selw_q == bus.i_chkA);
  assign bus.o_fwdB_valid = wen_q && (selw_q != '0) && (selw_q == bus.i_chkB);
  assign bus.o_fwdA_data  = wdata_q;
  assign bus.o_fwdB_data  = wdata_q;
`endif
endmodule

// File: tb/tb_argon_wb_arbiter.sv
// Directed vector bench for argon_wb_arbiter (two requesters, 8 registers).
module tb_argon_wb_arbiter;
  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  argon_wb_arbiter_if #(.REQUESTERS(2), .INDEXWIDTH(3), .DATAWIDTH(16)) bus ();

  argon_wb_arbiter #(.REQUESTERS(2), .REGISTERS(8), .INDEXWIDTH(3), .DATAWIDTH(16)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  valid;
    logic [2:0]  idx0;
    logic [2:0]  idx1;
    logic [15:0] d0;
    logic [15:0] d1;
    logic        rsv_en;
    logic [2:0]  rsv_idx;
    logic [2:0]  chka;
    logic [2:0]  chkb;
    logic [1:0]  e_ready;
    logic        e_stall;
    logic        e_busya;
    logic        e_busyb;
    logic        e_wen;
    logic [2:0]  e_selw;
    logic [15:0] e_wdata;
    logic        e_fwda;
    logic        e_fwdb;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic [1:0] valid, input logic [2:0] i0, input logic [2:0] i1,
                       input logic [15:0] d0, input logic [15:0] d1, input logic rsv_en,
                       input logic [2:0] rsv_idx, input logic [2:0] chka, input logic [2:0] chkb);
    bus.i_req_valid = valid;
    bus.i_req_index = {i1, i0};
    bus.i_req_data  = {d1, d0};
    bus.i_rsv_en    = rsv_en;
    bus.i_rsv_index = rsv_idx;
    bus.i_chkA      = chka;
    bus.i_chkB      = chkb;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    //            valid  i0    i1    d0        d1        ren   ridx  chkA  chkB  rdy    st    bA    bB    wen   selw  wdata     fA    fB
    vecs[0]  = '{2'b11, 3'd3, 3'd5, 16'hA000, 16'hB001, 1'b0, 3'd0, 3'd0, 3'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{2'b11, 3'd3, 3'd5, 16'hA002, 16'hB003, 1'b0, 3'd0, 3'd0, 3'd0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 16'hA000, 1'b0, 1'b0};
    vecs[2]  = '{2'b11, 3'd3, 3'd5, 16'hA004, 16'hB005, 1'b0, 3'd0, 3'd0, 3'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 16'hB003, 1'b0, 1'b0};
    vecs[3]  = '{2'b11, 3'd3, 3'd5, 16'hA006, 16'hB007, 1'b0, 3'd0, 3'd0, 3'd0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 16'hA004, 1'b0, 1'b0};
    vecs[4]  = '{2'b00, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b1, 3'd4, 3'd4, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 16'hB007, 1'b0, 1'b0};
    vecs[5]  = '{2'b10, 3'd0, 3'd4, 16'h0000, 16'hBEEF, 1'b0, 3'd0, 3'd4, 3'd0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 16'hB007, 1'b0, 1'b0};
    vecs[6]  = '{2'b00, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b0, 3'd0, 3'd4, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 16'hBEEF, 1'b1, 1'b0};
    vecs[7]  = '{2'b00, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b1, 3'd2, 3'd0, 3'd2, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 16'hBEEF, 1'b0, 1'b0};
    vecs[8]  = '{2'b00, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b1, 3'd2, 3'd0, 3'd2, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 16'hBEEF, 1'b0, 1'b0};
    vecs[9]  = '{2'b01, 3'd2, 3'd0, 16'h2222, 16'h0000, 1'b1, 3'd2, 3'd0, 3'd2, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 16'hBEEF, 1'b0, 1'b0};
    vecs[10] = '{2'b00, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b0, 3'd0, 3'd0, 3'd2, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 16'h2222, 1'b0, 1'b1};
    vecs[11] = '{2'b01, 3'd0, 3'd0, 16'h1234, 16'h0000, 1'b1, 3'd0, 3'd0, 3'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 16'h2222, 1'b0, 1'b0};
    vecs[12] = '{2'b00, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b0, 3'd0, 3'd0, 3'd2, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 16'h2222, 1'b0, 1'b0};
    vecs[13] = '{2'b10, 3'd0, 3'd6, 16'h0000, 16'h00AA, 1'b0, 3'd0, 3'd0, 3'd6, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 16'h2222, 1'b0, 1'b0};
    vecs[14] = '{2'b00, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b0, 3'd0, 3'd6, 3'd6, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd6, 16'h00AA, 1'b1, 1'b1};
    vecs[15] = '{2'b00, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b0, 3'd0, 3'd6, 3'd6, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd6, 16'h00AA, 1'b0, 1'b0};

    rst_n = 1'b0;
    drive(2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 1'b0, 3'd0, 3'd4, 3'd2);
    #1;
    chk("reset wen", {31'd0, bus.o_writeEn}, 32'd0);
    chk("reset selw", {29'd0, bus.o_selectW}, 32'd0);
    chk("reset wdata", {16'd0, bus.o_wdata}, 32'd0);
    chk("reset ready", {30'd0, bus.o_req_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].idx0, vecs[i].idx1, vecs[i].d0, vecs[i].d1,
            vecs[i].rsv_en, vecs[i].rsv_idx, vecs[i].chka, vecs[i].chkb);
      #1;
      chk($sformatf("v%0d ready", i), {30'd0, bus.o_req_ready}, {30'd0, vecs[i].e_ready});
      chk($sformatf("v%0d stall", i), {31'd0, bus.o_rsv_stall}, {31'd0, vecs[i].e_stall});
      chk($sformatf("v%0d busyA", i), {31'd0, bus.o_busyA}, {31'd0, vecs[i].e_busya});
      chk($sformatf("v%0d busyB", i), {31'd0, bus.o_busyB}, {31'd0, vecs[i].e_busyb});
      chk($sformatf("v%0d wen", i), {31'd0, bus.o_writeEn}, {31'd0, vecs[i].e_wen});
      chk($sformatf("v%0d selw", i), {29'd0, bus.o_selectW}, {29'd0, vecs[i].e_selw});
      chk($sformatf("v%0d wdata", i), {16'd0, bus.o_wdata}, {16'd0, vecs[i].e_wdata});
`ifdef ARGON_WB_FORWARD_EN
      chk($sformatf("v%0d fwdA_valid", i), {31'd0, bus.o_fwdA_valid}, {31'd0, vecs[i].e_fwda});
      chk($sformatf("v%0d fwdB_valid", i), {31'd0, bus.o_fwdB_valid}, {31'd0, vecs[i].e_fwdb});
      chk($sformatf("v%0d fwdB_data", i), {16'd0, bus.o_fwdB_data}, {16'd0, vecs[i].e_wdata});
`endif
    end

    // Mid-stream reset with a write in flight, busy bits set and the pointer at 1.
    @(negedge clk);
    drive(2'b11, 3'd3, 3'd5, 16'hA111, 16'hB111, 1'b1, 3'd3, 3'd3, 3'd2);
    #1;
    chk("pre-reset ready", {30'd0, bus.o_req_ready}, 32'd1);
    @(negedge clk);
    drive(2'b11, 3'd3, 3'd5, 16'hA111, 16'hB111, 1'b0, 3'd0, 3'd3, 3'd2);
    #1;
    chk("pre-reset wen", {31'd0, bus.o_writeEn}, 32'd1);
    chk("pre-reset busyA", {31'd0, bus.o_busyA}, 32'd1);
    chk("pre-reset busyB", {31'd0, bus.o_busyB}, 32'd1);
    chk("pre-reset ready ptr1", {30'd0, bus.o_req_ready}, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("async reset wen", {31'd0, bus.o_writeEn}, 32'd0);
    chk("async reset selw", {29'd0, bus.o_selectW}, 32'd0);
    chk("async reset wdata", {16'd0, bus.o_wdata}, 32'd0);
    chk("async reset busyA", {31'd0, bus.o_busyA}, 32'd0);
    chk("async reset busyB", {31'd0, bus.o_busyB}, 32'd0);
    chk("async reset ready", {30'd0, bus.o_req_ready}, 32'd1);
    @(negedge clk);
    chk("held reset wen", {31'd0, bus.o_writeEn}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post-reset ready", {30'd0, bus.o_req_ready}, 32'd1);
    @(negedge clk);
    drive(2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 1'b0, 3'd0, 3'd3, 3'd2);
    #1;
    chk("post-reset wen", {31'd0, bus.o_writeEn}, 32'd1);
    chk("post-reset selw", {29'd0, bus.o_selectW}, 32'd3);
    chk("post-reset wdata", {16'd0, bus.o_wdata}, 32'h0000A111);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
